// File: rtl/fetch_queue_pkg.sv
// fetch_queue_pkg: shared defaults, NOP constant and queue entry layout for the fetch queue
package fetch_queue_pkg;
  localparam int FQ_SIZE = 32;
  localparam int FQ_DEPTH = 4;
  localparam logic [31:0] NOP_INSTR = 32'h0;
  typedef struct packed {
    logic [FQ_SIZE-1:0] instruction;
    logic [FQ_SIZE-1:0] next_pc;
  } fq_entry_t;
endpackage

// File: rtl/fetch_queue_mem.sv
// fetch_queue_mem: unreset register array with synchronous write and asynchronous read
module fetch_queue_mem #(
  parameter int W = 64,
  parameter int DEPTH = 4,
  parameter int AW = 2
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);
  logic [W-1:0] mem [DEPTH];
  // write the addressed entry when enqueue fires
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end
  assign rdata = mem[raddr];
endmodule

// File: rtl/fetch_queue.sv
// fetch_queue: in-order instruction buffer between Fetch and Decode with flush and full stall
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int SIZE = FQ_SIZE,
  parameter int DEPTH = FQ_DEPTH,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_hit,
  input  logic [SIZE-1:0]  in_instruction,
  input  logic [SIZE-1:0]  in_next_pc,
  input  logic             flush,
  output logic             stall,
  output logic             out_valid,
  output logic [SIZE-1:0]  out_instruction,
  output logic [SIZE-1:0]  out_next_pc,
  input  logic             out_ready,
  output logic [PTR_W:0]   count
);
  logic [PTR_W-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [PTR_W:0] cnt_q, cnt_d;
  logic [2*SIZE-1:0] rdata;
  logic enq, deq;
  assign stall = cnt_q == (PTR_W+1)'(DEPTH);
  assign out_valid = cnt_q != '0;
  assign count = cnt_q;
  assign enq = in_hit & ~stall & ~flush;
  assign deq = out_valid & out_ready & ~flush;
  assign out_instruction = out_valid ? rdata[2*SIZE-1:SIZE] : SIZE'(NOP_INSTR);
  assign out_next_pc = out_valid ? rdata[SIZE-1:0] : '0;
  // pointers wrap naturally since DEPTH is a power of two; flush rewinds everything
  always_comb begin
    wr_d = flush ? '0 : enq ? wr_q + PTR_W'(1) : wr_q;
    rd_d = flush ? '0 : deq ? rd_q + PTR_W'(1) : rd_q;
    cnt_d = flush ? '0 : (enq & ~deq) ? cnt_q + 1'b1 : (deq & ~enq) ? cnt_q - 1'b1 : cnt_q;
  end
  // pointer and occupancy registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
    end
  end
  fetch_queue_mem #(.W(2*SIZE), .DEPTH(DEPTH), .AW(PTR_W)) u_mem (
    .clk(clk),
    .we(enq),
    .waddr(wr_q),
    .wdata({in_instruction, in_next_pc}),
    .raddr(rd_q),
    .rdata(rdata)
  );
endmodule
